// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit: operation modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-position shift step; also reports the bit that falls off the word.
module shift_step_unit
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e              mode_i,
  input  logic [WIDTH-1:0]   word_i,
  output logic [WIDTH-1:0]   word_o,
  output logic               out_bit_o
);

  always_comb begin
    word_o    = word_i;
    out_bit_o = 1'b0;
    unique case (mode_i)
      MODE_LSR: begin
        word_o    = {1'b0, word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      MODE_ASR: begin
        word_o    = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      MODE_LSL: begin
        word_o    = {word_i[WIDTH-2:0], 1'b0};
        out_bit_o = word_i[WIDTH-1];
      end
      MODE_ROR: begin
        word_o    = {word_i[0], word_i[WIDTH-1:1]};
        out_bit_o = word_i[0];
      end
      default: begin
        word_o    = word_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_right_shifter.sv
// Iterative multi-mode shifter, one bit per clock with a done pulse.
// Define SHIFTER_STICKY_EN to add the sticky_o output (OR of bits shifted out).
module param_right_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(WIDTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [AW-1:0]     amt_i,
  input  logic [WIDTH-1:0]  din_i,
  output logic [WIDTH-1:0]  dout_o,
  output logic              busy_o,
  output logic              done_o
`ifdef SHIFTER_STICKY_EN
  ,
  output logic              sticky_o
`endif
);

  localparam logic [AW-1:0] WidthAw = AW'(WIDTH);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] step_word;
  logic [AW-1:0]    amt_eff;
  mode_e            mode_in;

  assign mode_in = mode_e'(mode_i);

  // Rotation wraps; every other mode saturates at a full-width shift.
  always_comb begin
    if (mode_in == MODE_ROR) begin
      amt_eff = amt_i % WidthAw;
    end else begin
      amt_eff = (amt_i > WidthAw) ? WidthAw : amt_i;
    end
  end

`ifdef SHIFTER_STICKY_EN
  logic sticky_q, sticky_d;
  logic step_out;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i    (mode_q),
    .word_i    (dout_q),
    .word_o    (step_word),
    .out_bit_o (step_out)
  );
`else
  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i    (mode_q),
    .word_i    (dout_q),
    .word_o    (step_word),
    .out_bit_o ()
  );
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
`ifdef SHIFTER_STICKY_EN
    sticky_d = sticky_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dout_d  = din_i;
          mode_d  = mode_in;
          cnt_d   = amt_eff;
          state_d = (amt_eff == '0) ? ST_DONE : ST_SHIFT;
`ifdef SHIFTER_STICKY_EN
          sticky_d = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        dout_d = step_word;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = ST_DONE;
        end
`ifdef SHIFTER_STICKY_EN
        // Rotation loses no information, so it never sets sticky.
        if (mode_q != MODE_ROR) begin
          sticky_d = sticky_q | step_out;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_LSR;
      cnt_q    <= '0;
      dout_q   <= '0;
`ifdef SHIFTER_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
`ifdef SHIFTER_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done_o = (state_q == ST_DONE);
`ifdef SHIFTER_STICKY_EN
  assign sticky_o = sticky_q;
`endif

endmodule

// File: doc/param_right_shifter.md
Name: param_right_shifter

Overview:
- Parametrised, multi-mode, iterative shift unit. Successor to the fixed 4-bit right shifter.
- Accepts a WIDTH-bit operand, a mode and a shift amount on a start pulse.
- Shifts one bit position per clock and signals completion with a one-cycle done pulse.
- Sits in the datapath wherever a variable shift is needed and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 2.
- AW, $clog2(WIDTH)+1: width of the amt port; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- mode  input  2  00 LSR (logical right), 01 ASR (arithmetic right), 10 LSL (logical left), 11 ROR (rotate right)
- amt  input  AW  requested shift amount
- din  input  WIDTH  operand
- dout  output  WIDTH  working/result register
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; dout valid

Behaviour:
- Reset, applied on the clk edge where rst=1:
  - State goes to IDLE.
  - dout=0, busy=0, done=0 (sticky=0 if SHIFTER_STICKY_EN is defined).
  - rst dominates start and aborts any operation in flight; nothing else is emitted.
- Effective amount amt_eff:
  - ROR: amt mod WIDTH.
  - All other modes: min(amt, WIDTH), i.e. saturating.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches dout<=din, mode, and cnt<=amt_eff.
  - Next state is DONE if amt_eff==0, otherwise SHIFT.
  - start=0: dout holds.
- SHIFT, on each edge:
  - Apply one step and decrement cnt. Go to DONE when cnt reaches 0.
  - LSR: {0, dout[W-1:1]}.
  - ASR: {dout[W-1], dout[W-1:1]}.
  - LSL: {dout[W-2:0], 0}.
  - ROR: {dout[0], dout[W-1:1]}.
- DONE: done=1 for exactly one cycle, then IDLE. dout holds until the next accepted start.
- Latency:
  - If start is high in cycle 0, done is high in cycle amt_eff+1.
  - The next start can be accepted in cycle amt_eff+2.
- Boundary conditions:
  - start while busy=1 is ignored; no queueing.
  - din/mode/amt changes during busy have no effect.
  - amt >= WIDTH with LSR or LSL gives 0. With ASR it gives the sign fill (all bits = din[W-1]).
  - ROR with amt a multiple of WIDTH completes in 1 cycle with dout=din.
- Intermediate dout values during SHIFT are visible but not valid; consumers qualify on done.

Optional Feature:
- Macro: SHIFTER_STICKY_EN.
- Defined:
  - Adds output port sticky (1 bit), cleared on accepted start.
  - For LSR and ASR: ORs in each bit leaving dout[0].
  - For LSL: ORs in each bit leaving dout[W-1].
  - For ROR: held at 0.
  - Valid with done; holds until the next accepted start or rst.
- Undefined: no sticky port and no extra logic. All other behaviour is identical.

Decomposition:
- Shared package shifter_pkg holds:
  - Mode encodings: MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_LSL=2'b10, MODE_ROR=2'b11.
  - FSM state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step_unit: purely combinational single-bit step.
  - Inputs: mode, the word.
  - Outputs: the next word and the bit shifted out.
- Top level holds the FSM, the counter, the amt_eff computation and the registers.

Test Plan (WIDTH=8):
- LSR: din=0xB4, amt=3, start in cycle 0 -> done in cycle 4, dout=0x16; sticky=1 (if enabled).
- ASR: din=0x90, amt=2 -> done in cycle 3, dout=0xE4; sticky=0. Then ASR din=0x80, amt=15 (saturates to 8) -> dout=0xFF, done in cycle 9.
- ROR: din=0x81, amt=9 (amt_eff=1) -> done in cycle 2, dout=0xC0. Then ROR amt=8 -> done in cycle 1, dout=din.
- LSL: din=0x0F, amt=12 (saturates to 8) -> done in cycle 9, dout=0x00; sticky=1. Then amt=0 with din=0x5A -> done in cycle 1, dout=0x5A.
- start held high during a busy LSR of amt=5 -> only one done pulse, in cycle 6. A second start asserted in cycle 7 is accepted.
- rst=1 in cycle 2 of an amt=6 shift -> from the next cycle dout=0, busy=0, and done never pulses. A fresh start afterwards completes normally.
